// File: rtl/sgd_mem_rd_cmd_gen_pkg.sv
// sgd_mem_rd_cmd_gen_pkg: shared SGD sizing constants, read-command FSM states and helpers
package sgd_mem_rd_cmd_gen_pkg;
    localparam int A_FIFO_DEPTH_BITS = 11;
    localparam int SGD_CHUNK_BYTES   = 4096;
    localparam int SGD_LINE_BYTES    = 64;
    localparam int SGD_CREDITS       = 1 << A_FIFO_DEPTH_BITS;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} rd_state_e;

    // Byte count rounded up to whole 64-byte lines; one extra bit so 32-bit counts cannot wrap
    function automatic logic [32:0] round_up_line(input logic [31:0] n);
        return ({1'b0, n} + 33'd63) & ~33'd63;
    endfunction
endpackage

// File: rtl/sgd_mem_rd_cmd_gen_credit_cnt.sv
// sgd_credit_cnt: up/down counter that starts full, ignores increments at MAX and floors at zero
module sgd_credit_cnt #(
    parameter int MAX = 2048,
    parameter int W   = $clog2(MAX) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec_en,
    input  logic [W-1:0] dec_amt,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   up;

    // Net change in one step: capped increment first, then the bulk decrement
    always_comb begin
        up    = {1'b0, cnt_q} + {{W{1'b0}}, inc && cnt_q != W'(MAX)};
        cnt_d = !dec_en ? up[W-1:0] : (up >= {1'b0, dec_amt}) ? up[W-1:0] - dec_amt : '0;
    end

    // Counter register, full after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= W'(MAX);
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/sgd_mem_rd_cmd_gen.sv
// sgd_mem_rd_cmd_gen: splits a read job into chunk-bounded memory commands, paced by consumer line credits
module sgd_mem_rd_cmd_gen
    import sgd_mem_rd_cmd_gen_pkg::*;
#(
    parameter int CHUNK_BYTES = SGD_CHUNK_BYTES,
    parameter int LINE_BYTES  = SGD_LINE_BYTES,
    parameter int CREDITS     = SGD_CREDITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] base_addr,
    input  logic [31:0] total_bytes,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [63:0] cmd_address,
    output logic [31:0] cmd_length,
    input  logic        sts_valid,
    output logic        sts_ready,
    input  logic [7:0]  sts_data,
    input  logic        line_pop
);
    localparam int          CW    = $clog2(CREDITS) + 1;
    localparam int          LSH   = $clog2(LINE_BYTES);
    localparam logic [31:0] CHUNK = 32'(CHUNK_BYTES);

    rd_state_e   state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [32:0] rem_q, rem_d;
    logic [7:0]  outst_q, outst_d;
    logic        error_q, error_d;
    logic        zdone_q, zdone_d;
    logic [CW-1:0] credit;
    logic [31:0] room, len, lines32;
    logic        start_ok, credit_ok, cmd_hs, sts_hs;
    logic        unused_sts;

    assign unused_sts = ^sts_data[7:1];

    // Current command shape: stop at the next chunk boundary or at the end of the job
    always_comb begin
        room      = CHUNK - (addr_q[31:0] & (CHUNK - 32'd1));
        len       = (rem_q < {1'b0, room}) ? rem_q[31:0] : room;
        lines32   = len >> LSH;
        credit_ok = 32'(credit) >= lines32;
        start_ok  = state_q == ST_IDLE && start;
        cmd_hs    = cmd_valid && cmd_ready;
        sts_hs    = sts_valid;
    end

    sgd_credit_cnt #(.MAX(CREDITS), .W(CW)) u_credit (
        .clk     (clk),
        .rst     (rst),
        .inc     (line_pop),
        .dec_en  (cmd_hs),
        .dec_amt (lines32[CW-1:0]),
        .cnt     (credit)
    );

    // State register plus job datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            outst_q <= '0;
            error_q <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            outst_q <= outst_d;
            error_q <= error_d;
            zdone_q <= zdone_d;
        end
    end

    // Next state: issue until the last byte is commanded, then wait for every status
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = (start && total_bytes != 32'd0) ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = (cmd_hs && rem_q == {1'b0, len}) ? ST_DRAIN : ST_ISSUE;
            ST_DRAIN: state_d = (outst_q == 8'd0) ? ST_IDLE : ST_DRAIN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Job bookkeeping; outstanding holds on a simultaneous command and status and never wraps
    always_comb begin
        addr_d  = start_ok ? base_addr : cmd_hs ? addr_q + {32'd0, len} : addr_q;
        rem_d   = start_ok ? round_up_line(total_bytes) : cmd_hs ? rem_q - {1'b0, len} : rem_q;
        outst_d = (cmd_hs && !sts_hs && outst_q != 8'hFF) ? outst_q + 8'd1 :
                  (!cmd_hs && sts_hs && outst_q != 8'd0) ? outst_q - 8'd1 : outst_q;
        error_d = (start_ok ? 1'b0 : error_q) | (sts_hs && sts_data[0]);
        zdone_d = start_ok && total_bytes == 32'd0;
    end

    // Outputs: valid only with enough credit, done on the drain exit or after an empty job
    always_comb begin
        cmd_valid   = state_q == ST_ISSUE && credit_ok;
        cmd_address = addr_q;
        cmd_length  = len;
        busy        = state_q != ST_IDLE;
        done        = (state_q == ST_DRAIN && outst_q == 8'd0) || zdone_q;
        error       = error_q;
        sts_ready   = 1'b1;
    end
endmodule

// File: tb/tb_sgd_mem_rd_cmd_gen.sv
// tb_sgd_mem_rd_cmd_gen: table-driven and randomized checks of the read-command generator
module tb_sgd_mem_rd_cmd_gen;
    localparam int CHUNK   = 4096;
    localparam int CREDITS = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] base_addr = '0;
    logic [31:0] total_bytes = '0;
    logic        busy, done, error;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [63:0] cmd_address;
    logic [31:0] cmd_length;
    logic        sts_valid = 1'b0;
    logic        sts_ready;
    logic [7:0]  sts_data = '0;
    logic        line_pop = 1'b0;

    int checks = 0;
    int failures = 0;
    int m_credit = CREDITS;
    int m_fifo = 0;
    logic [63:0] exp_a[$];
    logic [31:0] exp_l[$];

    typedef struct {
        logic [63:0] b;
        logic [31:0] t;
        int          n;
        logic [63:0] a[3];
        logic [31:0] l[3];
        int          err;
    } vec_t;
    vec_t vecs[6];

    sgd_mem_rd_cmd_gen dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .total_bytes(total_bytes),
        .busy(busy), .done(done), .error(error),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_address(cmd_address), .cmd_length(cmd_length),
        .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_data(sts_data), .line_pop(line_pop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference split of a job into commands using plain arithmetic
    task automatic model_job(input logic [63:0] b, input logic [31:0] t);
        longint unsigned addr, rem, room, l;
        addr = b;
        rem = ((longint'(t) + 63) / 64) * 64;
        exp_a.delete();
        exp_l.delete();
        while (rem > 0) begin
            room = CHUNK - (addr % CHUNK);
            l = (rem < room) ? rem : room;
            exp_a.push_back(addr);
            exp_l.push_back(32'(l));
            addr += l;
            rem -= l;
        end
    endtask

    task automatic model_reset();
        m_credit = CREDITS;
        m_fifo = 0;
    endtask

    // Runs one job against the expected command queue, with random ready, pops and statuses
    task automatic run_job(input logic [63:0] b, input logic [31:0] t, input int stall_in,
                           input int err_idx, input int ready_pct, input int pop_pct);
        int pend, nsts, cyc, stall;
        bit done_seen, exp_err, ev;
        pend = 0; nsts = 0; cyc = 0; done_seen = 0; exp_err = 0; stall = stall_in;
        @(negedge clk);
        start = 1'b1; base_addr = b; total_bytes = t;
        @(negedge clk);
        start = 1'b0;
        chk("error_cleared_on_start", error, 1'b0);
        while (!done_seen) begin
            ev = exp_a.size() > 0 && m_credit >= int'(exp_l[0] / 64);
            chk("cmd_valid", cmd_valid, ev);
            if (cmd_valid && exp_a.size() > 0) begin
                chk("cmd_address", cmd_address, exp_a[0]);
                chk("cmd_length", cmd_length, exp_l[0]);
            end
            chk("busy", busy, t != 0);
            if (exp_a.size() == 0 && pend == 0) begin
                chk("done", done, 1'b1);
                chk("error_at_done", error, exp_err);
                done_seen = 1;
            end else begin
                chk("done_low", done, 1'b0);
            end
            if (done_seen) begin
                cmd_ready = 1'b0; line_pop = 1'b0; sts_valid = 1'b0;
            end else begin
                cmd_ready = (stall > 0) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
                if (cmd_valid && stall > 0) stall--;
                line_pop = m_fifo > 0 && $urandom_range(0, 99) < pop_pct;
                sts_valid = pend > 0 && $urandom_range(0, 1) == 1;
                sts_data = (nsts == err_idx) ? 8'h01 : 8'($urandom_range(0, 127) << 1);
                if (line_pop) begin
                    m_fifo--;
                    if (m_credit < CREDITS) m_credit++;
                end
                if (sts_valid) begin
                    pend--;
                    nsts++;
                    if (sts_data[0]) exp_err = 1;
                end
                if (cmd_valid && cmd_ready && exp_a.size() > 0) begin
                    m_credit -= int'(exp_l[0] / 64);
                    m_fifo += int'(exp_l[0] / 64);
                    pend++;
                    void'(exp_a.pop_front());
                    void'(exp_l.pop_front());
                end
            end
            @(negedge clk);
            cyc++;
            if (cyc > 5000) begin
                chk("job_timeout", 1'b1, 1'b0);
                break;
            end
        end
        cmd_ready = 1'b0; line_pop = 1'b0; sts_valid = 1'b0;
        chk("done_one_cycle", done, 1'b0);
        chk("idle_after_done", busy, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int cnt;
        vecs[0] = '{64'h0,   32'd10000, 3, '{64'h0, 64'h1000, 64'h2000}, '{32'd4096, 32'd4096, 32'd1856}, -1};
        vecs[1] = '{64'hF40, 32'd512,   2, '{64'hF40, 64'h1000, 64'h0},   '{32'd192, 32'd320, 32'd0},     -1};
        vecs[2] = '{64'h40,  32'd1,     1, '{64'h40, 64'h0, 64'h0},       '{32'd64, 32'd0, 32'd0},        -1};
        vecs[3] = '{64'h0,   32'd10000, 3, '{64'h0, 64'h1000, 64'h2000}, '{32'd4096, 32'd4096, 32'd1856}, 1};
        vecs[4] = '{64'h1000, 32'd0,    0, '{64'h0, 64'h0, 64'h0},        '{32'd0, 32'd0, 32'd0},         -1};
        vecs[5] = '{64'hFFC0, 32'd4096, 2, '{64'hFFC0, 64'h10000, 64'h0}, '{32'd64, 32'd4032, 32'd0},     -1};

        #1;
        chk("por_cmd_valid", cmd_valid, 1'b0);
        chk("por_busy", busy, 1'b0);
        chk("por_done", done, 1'b0);
        chk("por_error", error, 1'b0);
        chk("por_sts_ready", sts_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            exp_a.delete();
            exp_l.delete();
            for (int k = 0; k < vecs[i].n; k++) begin
                exp_a.push_back(vecs[i].a[k]);
                exp_l.push_back(vecs[i].l[k]);
            end
            run_job(vecs[i].b, vecs[i].t, (i == 0) ? 5 : 0, vecs[i].err, (i == 0) ? 100 : 70, 60);
        end

        // Credit exhaustion: pops at full credit are ignored, 32 commands drain all 2048 lines
        apply_reset();
        line_pop = 1'b1;
        for (int i = 0; i < 64; i++) @(negedge clk);
        line_pop = 1'b0;
        start = 1'b1; base_addr = 64'h0; total_bytes = 32'd262144; cmd_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (cmd_valid) cnt++;
            @(negedge clk);
        end
        cmd_ready = 1'b0;
        chk("credit_cmd_count", cnt, 32);
        chk("credit_stall_valid", cmd_valid, 1'b0);
        line_pop = 1'b1;
        for (int i = 0; i < 63; i++) @(negedge clk);
        line_pop = 1'b0;
        chk("credit_63_pops_valid", cmd_valid, 1'b0);
        line_pop = 1'b1;
        @(negedge clk);
        line_pop = 1'b0;
        chk("credit_64_pops_valid", cmd_valid, 1'b1);
        chk("credit_resume_addr", cmd_address, 64'h20000);
        chk("credit_resume_len", cmd_length, 32'd4096);

        // Reset mid-job after one command, then a stale status must not corrupt the next job
        apply_reset();
        start = 1'b1; base_addr = 64'h0; total_bytes = 32'd20000; cmd_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("midjob_first_valid", cmd_valid, 1'b1);
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("midjob_busy", busy, 1'b1);
        apply_reset();
        sts_valid = 1'b1; sts_data = 8'h00;
        @(negedge clk);
        sts_valid = 1'b0;
        chk("stale_sts_busy", busy, 1'b0);
        chk("stale_sts_done", done, 1'b0);
        model_job(64'h3000, 32'd9000);
        run_job(64'h3000, 32'd9000, 0, -1, 80, 50);

        for (int j = 0; j < 25; j++) begin
            logic [63:0] b;
            logic [31:0] t;
            b = {46'd0, 12'($urandom_range(0, 4095)), 6'd0};
            t = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 20000));
            model_job(b, t);
            run_job(b, t, $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1,
                    $urandom_range(30, 100), $urandom_range(20, 90));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
